model_buck_boost_l2: RTL and testbench

- Level 2 buck-boost converter model: N_CH independent converter channels time-multiplexed through one shared multiplier datapath.
- Adds three things Level 1 lacks:
  - optional discontinuous-conduction (diode blocking) mode;
  - saturating fixed-point arithmetic with sticky flags;
  - a start/busy/done step handshake.
- Sits between the switching-signal generator (PWM) and the measurement/DAC interface of the hardware-in-the-loop model chain.

---
 rtl/model_pkg.sv | 53 +++++
 rtl/model_fx_mul_sat.sv | 21 ++
 rtl/model_buck_boost_l2.sv | 197 +++++++++++++++++++
 tb/tb_model_buck_boost_l2.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/model_pkg.sv
// Shared types and fixed-point helpers for the buck-boost model.
// Helpers work on a wide signed intermediate so any W up to 64 fits.
package model_pkg;

  localparam int XW = 130;
  typedef logic signed [XW-1:0] wide_t;

  localparam logic [2:0] ENC_IDLE = 3'd0;
  localparam logic [2:0] ENC_RES  = 3'd1;
  localparam logic [2:0] ENC_IND  = 3'd2;
  localparam logic [2:0] ENC_CAP  = 3'd3;
  localparam logic [2:0] ENC_FIN  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = ENC_IDLE,
    ST_RES  = ENC_RES,
    ST_IND  = ENC_IND,
    ST_CAP  = ENC_CAP,
    ST_FIN  = ENC_FIN
  } state_t;

  function automatic wide_t sat_max(input int unsigned w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic logic sat_ovf(input wide_t x, input int unsigned w);
    return (x > sat_max(w)) || (x < (-sat_max(w) - wide_t'(1)));
  endfunction

  function automatic wide_t saturate(input wide_t x, input int unsigned w);
    wide_t v_max;
    wide_t v_min;
    v_max = sat_max(w);
    v_min = -v_max - wide_t'(1);
    if (x > v_max)
      return v_max;
    else if (x < v_min)
      return v_min;
    else
      return x;
  endfunction

  // Negation is applied to the full product before the shift.
  function automatic wide_t mul_shift(input wide_t a, input wide_t b,
                                      input int unsigned dec, input logic neg);
    wide_t v_p;
    v_p = a * b;
    if (neg)
      v_p = -v_p;
    return v_p >>> dec;
  endfunction

endpackage

// File: rtl/model_fx_mul_sat.sv
// Shared combinational fixed-point multiplier: (+/-)a*b >>> DEC, saturated to W bits.
module model_fx_mul_sat
  import model_pkg::*;
#(
  parameter int W   = 32,
  parameter int DEC = 24
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  input  logic                i_neg,
  output logic signed [W-1:0] o_p,
  output logic                o_ovf
);

  wide_t w_raw;

  assign w_raw = mul_shift(wide_t'(i_a), wide_t'(i_b), DEC, i_neg);
  assign o_p   = W'(saturate(w_raw, W));
  assign o_ovf = sat_ovf(w_raw, W);

endmodule

// File: rtl/model_buck_boost_l2.sv
// Level 2 buck-boost model: N_CH channels stepped in turn through one multiplier,
// with optional diode blocking, saturating arithmetic and a ce/busy/done handshake.
module model_buck_boost_l2
  import model_pkg::*;
#(
  parameter int MODEL_DATA_WIDTH         = 32,
  parameter int MODEL_DATA_WIDTH_DECIMAL = 24,
  parameter int N_CH                     = 2
) (
  input  logic                               aclk,
  input  logic                               resetn,
  input  logic                               ce,
  input  logic                               dcm_en,
  input  logic [N_CH-1:0]                    s1,
  input  logic [MODEL_DATA_WIDTH-1:0]        kL,
  input  logic [MODEL_DATA_WIDTH-1:0]        kC,
  input  logic [MODEL_DATA_WIDTH-1:0]        kR,
  input  logic [MODEL_DATA_WIDTH-1:0]        vdc,
  output logic [N_CH*MODEL_DATA_WIDTH-1:0]   iL,
  output logic [N_CH*MODEL_DATA_WIDTH-1:0]   vO,
  output logic [N_CH*MODEL_DATA_WIDTH-1:0]   iO,
  output logic                               busy,
  output logic                               done,
  output logic                               sat,
  output logic                               overrun
);

  localparam int W  = MODEL_DATA_WIDTH;
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [CW-1:0]         r_ch;
  logic [N_CH-1:0]       r_s1c;
  logic                  r_dcm;
  logic signed [W-1:0]   r_il [N_CH];
  logic signed [W-1:0]   r_vo [N_CH];
  logic signed [W-1:0]   r_io [N_CH];
  logic signed [W-1:0]   r_io_cur;
  logic signed [W-1:0]   r_pl;
  logic                  r_sat;
  logic                  r_overrun;

  logic                  w_s1_ch;
  logic signed [W-1:0]   w_il_ch;
  logic signed [W-1:0]   w_vo_ch;
  logic signed [W-1:0]   w_vl;
  logic signed [W-1:0]   w_mul_a;
  logic signed [W-1:0]   w_mul_b;
  logic                  w_mul_neg;
  logic signed [W-1:0]   w_mul_p;
  logic                  w_mul_ovf;
  wide_t                 w_il_sum;
  logic signed [W-1:0]   w_il_sat;
  logic signed [W-1:0]   w_il_n;
  logic                  w_diode_off;
  wide_t                 w_ic_raw;
  logic signed [W-1:0]   w_ic;
  wide_t                 w_vo_sum;
  logic signed [W-1:0]   w_vo_n;
  logic                  w_cap_ovf;
  logic                  w_sat_evt;

  assign w_s1_ch = r_s1c[r_ch];
  assign w_il_ch = r_il[r_ch];
  assign w_vo_ch = r_vo[r_ch];
  assign w_vl    = w_s1_ch ? $signed(vdc) : w_vo_ch;

  // The CAP-phase current and voltage update, all from pre-step values.
  assign w_il_sum    = wide_t'(w_il_ch) + wide_t'(r_pl);
  assign w_il_sat    = W'(saturate(w_il_sum, W));
  assign w_diode_off = !w_s1_ch && r_dcm && (w_il_ch <= 0);
  assign w_il_n      = (!w_s1_ch && r_dcm && (w_diode_off || (w_il_sat < 0))) ? '0 : w_il_sat;
  assign w_ic_raw    = (w_s1_ch || w_diode_off) ? -wide_t'(r_io_cur)
                                                : wide_t'(w_il_ch) - wide_t'(r_io_cur);
  assign w_ic        = W'(saturate(w_ic_raw, W));
  assign w_vo_sum    = wide_t'(w_vo_ch) + wide_t'(w_mul_p);
  assign w_vo_n      = W'(saturate(w_vo_sum, W));
  assign w_cap_ovf   = sat_ovf(w_il_sum, W) || sat_ovf(w_ic_raw, W) || sat_ovf(w_vo_sum, W);

  always_comb begin
    w_mul_a   = '0;
    w_mul_b   = '0;
    w_mul_neg = 1'b0;
    w_sat_evt = 1'b0;
    case (r_state)
      ST_RES: begin
        w_mul_a   = w_vo_ch;
        w_mul_b   = $signed(kR);
        w_sat_evt = w_mul_ovf;
      end
      ST_IND: begin
        w_mul_a   = w_vl;
        w_mul_b   = $signed(kL);
        w_mul_neg = 1'b1;
        w_sat_evt = w_mul_ovf;
      end
      ST_CAP: begin
        w_mul_a   = w_ic;
        w_mul_b   = $signed(kC);
        w_sat_evt = w_mul_ovf || w_cap_ovf;
      end
      default: ;
    endcase
  end

  model_fx_mul_sat #(
    .W   (W),
    .DEC (MODEL_DATA_WIDTH_DECIMAL)
  ) u_mul (
    .i_a   (w_mul_a),
    .i_b   (w_mul_b),
    .i_neg (w_mul_neg),
    .o_p   (w_mul_p),
    .o_ovf (w_mul_ovf)
  );

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: if (ce) w_state_next = ST_RES;
      ST_RES: begin
        busy         = 1'b1;
        w_state_next = ST_IND;
      end
      ST_IND: begin
        busy         = 1'b1;
        w_state_next = ST_CAP;
      end
      ST_CAP: begin
        busy         = 1'b1;
        w_state_next = (r_ch == LAST_CH) ? ST_FIN : ST_RES;
      end
      ST_FIN: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_ch      <= '0;
      r_s1c     <= '0;
      r_dcm     <= 1'b0;
      r_io_cur  <= '0;
      r_pl      <= '0;
      r_sat     <= 1'b0;
      r_overrun <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        r_il[k] <= '0;
        r_vo[k] <= '0;
        r_io[k] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      if (ce && (r_state != ST_IDLE))
        r_overrun <= 1'b1;
      if (w_sat_evt)
        r_sat <= 1'b1;
      case (r_state)
        ST_IDLE: if (ce) begin
          r_s1c <= s1;
          r_dcm <= dcm_en;
          r_ch  <= '0;
        end
        ST_RES: begin
          r_io[r_ch] <= w_mul_p;
          r_io_cur   <= w_mul_p;
        end
        ST_IND: r_pl <= w_mul_p;
        ST_CAP: begin
          r_il[r_ch] <= w_il_n;
          r_vo[r_ch] <= w_vo_n;
          if (r_ch != LAST_CH)
            r_ch <= r_ch + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_pack
    assign iL[gi*W +: W] = r_il[gi];
    assign vO[gi*W +: W] = r_vo[gi];
    assign iO[gi*W +: W] = r_io[gi];
  end

  assign sat     = r_sat;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_model_buck_boost_l2.sv
// Directed and randomized steps of the buck-boost model against an arithmetic reference.
module tb_model_buck_boost_l2;

  localparam int W = 32;
  localparam int D = 24;
  localparam int N = 2;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic aclk = 1'b0;
  logic resetn = 1'b0;
  logic ce = 1'b0;
  logic dcm_en = 1'b0;
  logic [N-1:0] s1 = '0;
  logic [W-1:0] kL = '0, kC = '0, kR = '0, vdc = '0;
  logic [N*W-1:0] iL, vO, iO;
  logic busy, done, sat, overrun;

  int tests = 0;
  int fails = 0;

  longint m_il [N];
  longint m_vo [N];
  longint m_io [N];
  bit m_sat = 1'b0;
  bit m_ovr = 1'b0;

  model_buck_boost_l2 #(
    .MODEL_DATA_WIDTH(W), .MODEL_DATA_WIDTH_DECIMAL(D), .N_CH(N)
  ) dut (
    .aclk(aclk), .resetn(resetn), .ce(ce), .dcm_en(dcm_en), .s1(s1),
    .kL(kL), .kC(kC), .kR(kR), .vdc(vdc),
    .iL(iL), .vO(vO), .iO(iO),
    .busy(busy), .done(done), .sat(sat), .overrun(overrun)
  );

  always #5 aclk = ~aclk;

  function automatic longint clampw(longint x);
    if (x > MAXV) begin m_sat = 1'b1; return MAXV; end
    if (x < MINV) begin m_sat = 1'b1; return MINV; end
    return x;
  endfunction

  function automatic longint fx(longint p);
    return p >>> D;
  endfunction

  function automatic longint sx(logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  // One forward-Euler step per channel, all from the values before the step.
  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      longint io_n, vl, pl, il_n, ic, vo_n;
      bit s, off;
      s    = s1[c];
      io_n = clampw(fx(m_vo[c] * sx(kR)));
      vl   = s ? sx(vdc) : m_vo[c];
      pl   = clampw(fx(-(vl * sx(kL))));
      il_n = clampw(m_il[c] + pl);
      off  = !s && dcm_en && (m_il[c] <= 0);
      if (!s && dcm_en && (off || il_n < 0)) il_n = 0;
      ic   = (s || off) ? clampw(-io_n) : clampw(m_il[c] - io_n);
      vo_n = clampw(m_vo[c] + clampw(fx(ic * sx(kC))));
      m_io[c] = io_n;
      m_il[c] = il_n;
      m_vo[c] = vo_n;
    end
  endtask

  task automatic check(string tag, longint obs, longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint dut_il(int c); return sx(iL[c*W +: W]); endfunction
  function automatic longint dut_vo(int c); return sx(vO[c*W +: W]); endfunction
  function automatic longint dut_io(int c); return sx(iO[c*W +: W]); endfunction

  task automatic check_all(string tag);
    for (int c = 0; c < N; c++) begin
      check($sformatf("%s.iL%0d", tag, c), dut_il(c), m_il[c]);
      check($sformatf("%s.vO%0d", tag, c), dut_vo(c), m_vo[c]);
      check($sformatf("%s.iO%0d", tag, c), dut_io(c), m_io[c]);
    end
    check({tag, ".sat"}, longint'(sat), longint'(m_sat));
    check({tag, ".overrun"}, longint'(overrun), longint'(m_ovr));
  endtask

  task automatic do_step(string tag, int extra_ce = -1);
    int cnt;
    model_step();
    if (extra_ce >= 0) m_ovr = 1'b1;
    @(negedge aclk); ce = 1'b1;
    @(negedge aclk); ce = 1'b0;
    cnt = 1;
    check({tag, ".busy"}, longint'(busy), 1);
    while (!done && cnt < 40) begin
      if (cnt == extra_ce) ce = 1'b1;
      @(negedge aclk);
      ce = 1'b0;
      cnt++;
    end
    check({tag, ".latency"}, cnt, 3*N + 1);
    @(negedge aclk);
    check({tag, ".done_pulse"}, longint'(done), 0);
    check({tag, ".busy_end"}, longint'(busy), 0);
    $display("[TB] step %s: cycles=%0d iL0=%0d vO0=%0d iO0=%0d iL1=%0d vO1=%0d sat=%0b ovr=%0b",
             tag, cnt, dut_il(0), dut_vo(0), dut_io(0), dut_il(1), dut_vo(1), sat, overrun);
    check_all(tag);
  endtask

  initial begin
    for (int c = 0; c < N; c++) begin m_il[c] = 0; m_vo[c] = 0; m_io[c] = 0; end

    // Reset state
    repeat (3) @(negedge aclk);
    check_all("reset");
    check("reset.busy", longint'(busy), 0);
    check("reset.done", longint'(done), 0);
    resetn = 1'b1;
    @(negedge aclk);

    // Buck-boost charging from vdc = 1.0 with kL = -0.01
    s1 = '1; dcm_en = 1'b0; vdc = 32'h0100_0000; kL = -32'sd167772; kC = '0; kR = '0;
    do_step("basic");
    check("basic.iL0_const", dut_il(0), 64'h0002_8F5C);
    check("basic.iL1_const", dut_il(1), 64'h0002_8F5C);
    for (int i = 1; i < 100; i++) do_step($sformatf("ramp%0d", i));
    check("ramp.iL0_const", dut_il(0), 16777200);
    check("ramp.iL1_near_one", longint'((dut_il(1) - 16777216) <= 100 && (dut_il(1) - 16777216) >= -100), 1);
    check("ramp.sat0", longint'(sat), 0);

    // Build vO near 2.0 through the capacitor path
    s1 = '0; kL = '0; kC = 32'h0200_0000; kR = '0;
    do_step("preset");

    // Diode blocking: current clamps to zero and stays there
    dcm_en = 1'b1; kL = 32'h0100_0000; kC = '0; kR = 32'h0080_0000;
    do_step("dcm_clamp");
    check("dcm_clamp.iL0_zero", dut_il(0), 0);
    kC = 32'sd167772;
    do_step("dcm_hold1");
    do_step("dcm_hold2");
    check("dcm_hold.iL1_zero", dut_il(1), 0);

    // Continuous conduction: current goes negative
    dcm_en = 1'b0;
    do_step("ccm_neg");
    check("ccm_neg.iL0_negative", longint'(dut_il(0) < 0), 1);
    check("ccm_neg.sat0", longint'(sat), 0);

    // Randomized operating points
    for (int i = 0; i < 20; i++) begin
      s1     = N'($urandom_range(0, (1 << N) - 1));
      dcm_en = 1'($urandom_range(0, 1));
      kL  = 32'(int'($urandom_range(0, 1 << 23)) - (1 << 22));
      kC  = 32'(int'($urandom_range(0, 1 << 23)) - (1 << 22));
      kR  = 32'(int'($urandom_range(0, 1 << 23)) - (1 << 22));
      vdc = 32'(int'($urandom_range(0, 1 << 26)) - (1 << 25));
      do_step($sformatf("rand%0d", i));
    end

    // ce while busy: flagged, ignored, single done
    s1 = '1; dcm_en = 1'b0; vdc = 32'h0100_0000; kL = -32'sd167772; kC = '0; kR = '0;
    do_step("overrun", 2);
    check("overrun.flag", longint'(overrun), 1);
    repeat (3) begin
      @(negedge aclk);
      check("overrun.no_second_done", longint'(done), 0);
    end

    // Saturation pins iL at the negative limit
    kL = 32'h7FFF_FFFF; vdc = 32'h7FFF_FFFF;
    for (int i = 0; i < 3; i++) do_step($sformatf("satpin%0d", i));
    check("satpin.iL0_min", dut_il(0), MINV);
    check("satpin.iL1_min", dut_il(1), MINV);
    check("satpin.sat1", longint'(sat), 1);

    // Reset during CAP of channel 1 aborts the step
    @(negedge aclk); ce = 1'b1;
    @(negedge aclk); ce = 1'b0;
    repeat (5) @(negedge aclk);
    resetn = 1'b0;
    #1;
    for (int c = 0; c < N; c++) begin m_il[c] = 0; m_vo[c] = 0; m_io[c] = 0; end
    m_sat = 1'b0; m_ovr = 1'b0;
    check_all("midreset");
    check("midreset.busy", longint'(busy), 0);
    @(negedge aclk);
    resetn = 1'b1;
    @(negedge aclk);
    kL = -32'sd167772; vdc = 32'h0100_0000;
    do_step("post_reset");
    check("post_reset.iL0_const", dut_il(0), 64'h0002_8F5C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
